// File: rtl/mic_clock_gen.sv
`timescale 1ns/1ps
// mic_clock_gen: PDM mic clock, DDR capture strobes, lr_clk and frame
// strobe, all phase-locked to one hc/mc counter chain.
//   in : clk, rst (async active-low), en, div_half[DIV_W]
//   out: mic_clk, mic_rise, mic_fall, lr_clk, frame_stb, running
module mic_clock_gen #(
  parameter int DECIM = 64,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_half,
  output logic             mic_clk,
  output logic             mic_rise,
  output logic             mic_fall,
  output logic             lr_clk,
  output logic             frame_stb,
  output logic             running
);

  localparam int MC_W = $clog2(DECIM);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(DECIM - 1);
  localparam logic [MC_W-1:0] MC_HALF = MC_W'(DECIM / 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hc;
  logic [MC_W-1:0]  mc;

  logic [DIV_W-1:0] div_sel;
  logic [MC_W-1:0]  mc_nxt;
  logic             hc_end;
  logic             mc_last;
  logic             bnd;

  always_comb begin
    div_sel = (div_half == '0) ? DIV_W'(1) : div_half;
    hc_end  = (hc == div_q - DIV_W'(1));
    mc_last = (mc == MC_LAST);
    mc_nxt  = mc_last ? '0 : mc + MC_W'(1);
    // frame boundary: falling toggle that wraps mc
    bnd     = hc_end & mic_clk & mc_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_q     <= DIV_W'(1);
      hc        <= '0;
      mc        <= '0;
      mic_clk   <= 1'b0;
      mic_rise  <= 1'b0;
      mic_fall  <= 1'b0;
      lr_clk    <= 1'b0;
      frame_stb <= 1'b0;
      running   <= 1'b0;
    end else begin
      mic_rise  <= 1'b0;
      mic_fall  <= 1'b0;
      frame_stb <= 1'b0;
      case (state)
        IDLE: begin
          hc <= '0;
          mc <= '0;
          if (en) begin
            state     <= RUN;
            div_q     <= div_sel;
            mic_clk   <= 1'b0;
            lr_clk    <= 1'b0;
            frame_stb <= 1'b1;
            running   <= 1'b1;
          end
        end
        default: begin
          if (hc_end) begin
            hc      <= '0;
            mic_clk <= ~mic_clk;
            if (!mic_clk) begin
              mic_rise <= 1'b1;
            end else begin
              mic_fall <= 1'b1;
              mc       <= mc_nxt;
              lr_clk   <= (mc_nxt >= MC_HALF);
              if (mc_last) begin
                frame_stb <= 1'b1;
                div_q     <= div_sel;
              end
            end
          end else begin
            hc <= hc + DIV_W'(1);
          end
          state <= en ? RUN : DRAIN;
          // drained to the frame end: stop cleanly,
          // the final mic_fall strobe still marks the edge
          if (state == DRAIN && bnd && !en) begin
            state     <= IDLE;
            hc        <= '0;
            mc        <= '0;
            mic_clk   <= 1'b0;
            lr_clk    <= 1'b0;
            frame_stb <= 1'b0;
            running   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_clock_gen.sv
`timescale 1ns/1ps
// tb_mic_clock_gen: directed checks of mic_clock_gen
// (DECIM=64) timing, reload, drain and reset behaviour.
module tb_mic_clock_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_half;
  logic       mic_clk, mic_rise, mic_fall;
  logic       lr_clk, frame_stb, running;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_lr = 1'b0;

  int f_len, f_r, f_f, f_lh, f_s, f_b, f_q, f_nr, f_mn, f_mx;

  always #5 clk = ~clk;

  mic_clock_gen #(.DECIM(64), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div_half(div_half),
    .mic_clk(mic_clk), .mic_rise(mic_rise),
    .mic_fall(mic_fall), .lr_clk(lr_clk),
    .frame_stb(frame_stb), .running(running)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    prev_lr = lr_clk;
    @(negedge clk);
    cyc++;
  endtask

  function automatic int outs();
    return int'({frame_stb, running, mic_clk,
                 lr_clk, mic_rise, mic_fall});
  endfunction

  // Runs from the current cycle up to and including the
  // next frame_stb cycle (or until running drops).
  task automatic run_frame(input int chg_at,
                           input int chg_val,
                           input int off_at,
                           input int on_at);
    int last;
    last = -1;
    f_len = 0; f_r = 0; f_f = 0; f_lh = 0; f_s = 0;
    f_b = 0; f_q = 0; f_nr = 0;
    f_mn = 32'h7fffffff; f_mx = 0;
    do begin
      tick();
      f_len++;
      if (mic_rise) begin
        f_r++;
        if (last >= 0) begin
          if (cyc - last < f_mn) f_mn = cyc - last;
          if (cyc - last > f_mx) f_mx = cyc - last;
        end
        last = cyc;
      end
      if (mic_fall) begin
        f_f++;
        if (f_f == chg_at) div_half = 8'(chg_val);
        if (f_f == off_at) en = 1'b0;
        if (f_f == on_at) en = 1'b1;
      end
      if (lr_clk) f_lh++;
      if (frame_stb) f_s++;
      if (mic_rise && mic_fall) f_b++;
      if (!mic_rise && !mic_fall) f_q++;
      if (!running) f_nr++;
    end while (!frame_stb && running && f_len < 4000);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    div_half = 8'd2;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_outs", outs(), 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_en0_outs", outs(), 0);

    en = 1'b1;
    tick();
    chk("start_outs", outs(), 6'b110000);

    // div_half=2: period 4, frame 256
    for (int k = 0; k < 8; k++) begin
      run_frame(-1, 0, -1, -1);
      chk($sformatf("f%0d_len", k), f_len, 256);
      chk($sformatf("f%0d_rise", k), f_r, 64);
      chk($sformatf("f%0d_fall", k), f_f, 64);
      chk($sformatf("f%0d_stb", k), f_s, 1);
      chk($sformatf("f%0d_lrhigh", k), f_lh, 128);
      chk($sformatf("f%0d_both", k), f_b, 0);
      chk($sformatf("f%0d_per", k), f_mn, 4);
    end
    chk("stb_with_fall", int'(mic_fall), 1);
    chk("lr_falls_at_stb", int'({prev_lr, lr_clk}), 2);

    // div_half=0 -> 1 from the following frame
    div_half = 8'd0;
    run_frame(-1, 0, -1, -1);
    chk("d0_old_len", f_len, 256);
    run_frame(-1, 0, -1, -1);
    chk("d0_len", f_len, 128);
    chk("d0_rise", f_r, 64);
    chk("d0_fall", f_f, 64);
    chk("d0_quiet", f_q, 0);
    chk("d0_pmin", f_mn, 2);
    chk("d0_pmax", f_mx, 2);

    // back to 2, then 2->3 at mc=10
    div_half = 8'd2;
    run_frame(-1, 0, -1, -1);
    chk("d2_old_len", f_len, 128);
    run_frame(10, 3, -1, -1);
    chk("chg_len", f_len, 256);
    chk("chg_pmin", f_mn, 4);
    chk("chg_pmax", f_mx, 4);
    chk("chg_rise", f_r, 64);
    run_frame(-1, 0, -1, -1);
    chk("d3_len", f_len, 384);
    chk("d3_pmin", f_mn, 6);
    chk("d3_pmax", f_mx, 6);
    chk("d3_lrhigh", f_lh, 192);

    // en=0 at mc=20 -> drain 44 more falls, then IDLE
    run_frame(-1, 0, 20, -1);
    chk("drain_len", f_len, 384);
    chk("drain_fall", f_f - 20, 44);
    chk("drain_stb", f_s, 0);
    chk("drain_end_run", int'(running), 0);
    tick();
    chk("drain_idle_outs", outs(), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("drain_idle_outs2", outs(), 0);

    en = 1'b1;
    tick();
    chk("restart_outs", outs(), 6'b110000);
    run_frame(-1, 0, -1, -1);
    chk("restart_len", f_len, 384);
    // en off at 20, back on at 40: no phase gap
    run_frame(-1, 0, 20, 40);
    chk("reen_len", f_len, 384);
    chk("reen_fall", f_f, 64);
    chk("reen_stb", f_s, 1);
    chk("reen_notrun", f_nr, 0);
    chk("reen_pmin", f_mn, 6);
    chk("reen_pmax", f_mx, 6);
    run_frame(-1, 0, -1, -1);
    chk("reen_next_len", f_len, 384);

    // async reset mid-frame
    for (int i = 0; i < 50; i++) tick();
    chk("pre_rst_run", int'(running), 1);
    #2 rst = 1'b0;
    #1 chk("async_rst_outs", outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_outs", outs(), 6'b110000);
    run_frame(-1, 0, -1, -1);
    chk("post_rst_len", f_len, 384);
    chk("post_rst_fall", f_f, 64);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
